sync_capture: RTL and testbench

Receive-side data pipeline for the synchronizer datapath, sitting directly downstream of the staggered enable generator in the clkB domain. It consumes the three enables `ena_1`/`ena_2`/`ena_3` and uses them to walk an N-bit word from the clkA-domain bus through three load-enabled register stages. It checks that the enable sequence is legal and presents the transferred word with a one-cycle `valid` strobe. It also keeps a transfer count and sticky error flags for the top-level status readout.

---
 rtl/sync_capture.sv | 126 ++++++++++++
 tb/tb_sync_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_capture.sv
// Receive-side capture pipeline: walks a clkA word through three enable-loaded stages,
// checks the staggered enable sequence, and reports completed transfers.
// Optional data-stability checker enabled by defining SYNC_CAPTURE_CHECK_EN.
module sync_capture #(
    parameter int N = 8
) (
    input  logic         clkB,
    input  logic         rst_n,
    input  logic [N-1:0] data_in,
    input  logic         ena_1,
    input  logic         ena_2,
    input  logic         ena_3,
    input  logic         clr,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         busy,
    output logic [7:0]   xfer_cnt,
    output logic         seq_err,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST1  = 2'd1,
        ST2  = 2'd2,
        ST3  = 2'd3
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] s1, s2, s3;
    logic [2:0]   ena_vec;
    logic         complete;
    logic         seq_set;

    assign ena_vec = {ena_1, ena_2, ena_3};
    assign busy    = (state != IDLE);

    // NOTE: every registered signal uses <= so all right-hand sides see pre-edge values,
    // which is what lets s2 <= s1 and s3 <= s2 shift in the same edge.
    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            if (ena_1) s1 <= data_in;
            if (ena_2) s2 <= s1;
            if (ena_3) s3 <= s2;
        end
    end

    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults assigned first so no path through the case leaves an output unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        seq_set   = 1'b0;
        case (state)
            IDLE: begin
                if (ena_vec == 3'b111)      state_nxt = ST1;
                else if (ena_vec != 3'b000) seq_set   = 1'b1;
            end
            ST1: begin
                if (ena_vec == 3'b011) state_nxt = ST2;
                else begin
                    seq_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ST2: begin
                if (ena_vec == 3'b001) state_nxt = ST3;
                else begin
                    seq_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ST3: begin
                state_nxt = IDLE;
                if (ena_vec == 3'b000) complete = 1'b1;
                else                   seq_set  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= complete;
            if (complete) data_out <= s3;
        end
    end

    // clr wins over increment and flag set in the same cycle.
    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
            seq_err  <= 1'b0;
        end else if (clr) begin
            xfer_cnt <= '0;
            seq_err  <= 1'b0;
        end else begin
            if (complete) xfer_cnt <= xfer_cnt + 8'd1;
            if (seq_set)  seq_err  <= 1'b1;
        end
    end

`ifdef SYNC_CAPTURE_CHECK_EN
    // s1 holds the word sampled at the start edge; any later difference means the source moved.
    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n)                              err <= 1'b0;
        else if (clr)                            err <= 1'b0;
        else if (state != IDLE && data_in != s1) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_capture.sv
// Randomized self-checking bench for sync_capture against a transfer-level reference model.
module tb_sync_capture;

    localparam int N = 8;

    logic         clkB = 1'b0;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic         ena_1, ena_2, ena_3;
    logic         clr;
    logic [N-1:0] data_out;
    logic         valid, busy, seq_err, err;
    logic [7:0]   xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: progress index into the legal enable sequence, plus stage contents.
    logic [2:0]   legal_seq [4] = '{3'b111, 3'b011, 3'b001, 3'b000};
    int           m_pos;
    logic [N-1:0] m_stage [1:3];
    logic [N-1:0] m_out;
    bit           m_valid, m_seq, m_err;
    int           m_cnt;

    always #5 clkB = ~clkB;

    sync_capture #(.N(N)) dut (
        .clkB    (clkB),
        .rst_n   (rst_n),
        .data_in (data_in),
        .ena_1   (ena_1),
        .ena_2   (ena_2),
        .ena_3   (ena_3),
        .clr     (clr),
        .data_out(data_out),
        .valid   (valid),
        .busy    (busy),
        .xfer_cnt(xfer_cnt),
        .seq_err (seq_err),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        for (int i = 1; i <= 3; i++) m_stage[i] = '0;
        m_out   = '0;
        m_valid = 0;
        m_seq   = 0;
        m_err   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(m_out));
        check({tag, ".valid"},    32'(valid),    32'(m_valid));
        check({tag, ".busy"},     32'(busy),     32'(m_pos != 0));
        check({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
        check({tag, ".seq_err"},  32'(seq_err),  32'(m_seq));
        check({tag, ".err"},      32'(err),      32'(m_err));
    endtask

    // One clock: drive inputs, advance the model by the spec rules, then compare after the edge.
    task automatic step(input string tag, input logic [2:0] e, input logic [N-1:0] d, input bit c);
        bit done, bad, moved;
        logic [N-1:0] old1, old2;
        {ena_1, ena_2, ena_3} = e;
        data_in = d;
        clr     = c;

        done  = 0;
        bad   = 0;
        moved = (m_pos != 0) && (d != m_stage[1]);
        if (m_pos == 0) begin
            if (e == legal_seq[0]) m_pos = 1;
            else if (e != 3'b000)  bad = 1;
        end else if (e == legal_seq[m_pos]) begin
            m_pos++;
            if (m_pos == 4) begin
                done  = 1;
                m_pos = 0;
            end
        end else begin
            bad   = 1;
            m_pos = 0;
        end

        m_valid = done;
        if (done) m_out = m_stage[3];
        if (c) begin
            m_cnt = 0;
            m_seq = 0;
            m_err = 0;
        end else begin
            if (done) m_cnt = (m_cnt + 1) % 256;
            if (bad)  m_seq = 1;
`ifdef SYNC_CAPTURE_CHECK_EN
            if (moved) m_err = 1;
`endif
        end
        old1 = m_stage[1];
        old2 = m_stage[2];
        if (e[2]) m_stage[1] = d;
        if (e[1]) m_stage[2] = old1;
        if (e[0]) m_stage[3] = old2;

        @(posedge clkB);
        #1;
        check_outputs(tag);
    endtask

    task automatic legal_xfer(input string tag, input logic [N-1:0] d, input bit clr_last);
        step(tag, 3'b111, d, 0);
        step(tag, 3'b011, d, 0);
        step(tag, 3'b001, d, 0);
        step(tag, 3'b000, d, clr_last);
    endtask

    task automatic idle_cycle(input string tag);
        step(tag, 3'b000, data_in, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = '0;
        {ena_1, ena_2, ena_3} = 3'b000;
        clr     = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(posedge clkB);
        #1;
        rst_n = 1'b1;

        // Basic transfer; valid lands 3 cycles after the sampling edge.
        step("a5", 3'b111, 8'hA5, 0);
        check("a5.busy1", 32'(busy), 32'd1);
        step("a5", 3'b011, 8'hA5, 0);
        step("a5", 3'b001, 8'hA5, 0);
        check("a5.novalid", 32'(valid), 32'd0);
        step("a5", 3'b000, 8'hA5, 0);
        check("a5.valid", 32'(valid), 32'd1);
        check("a5.data", 32'(data_out), 32'hA5);
        check("a5.cnt", 32'(xfer_cnt), 32'd1);
        idle_cycle("a5.after");
        check("a5.pulse1", 32'(valid), 32'd0);

        // Back-to-back transfers.
        legal_xfer("b2b0", 8'h3C, 0);
        check("b2b0.data", 32'(data_out), 32'h3C);
        legal_xfer("b2b1", 8'hC3, 0);
        check("b2b1.data", 32'(data_out), 32'hC3);
        check("b2b1.cnt", 32'(xfer_cnt), 32'd3);

        // Illegal start pattern, then clr, then a legal transfer.
        step("ill", 3'b011, 8'h55, 0);
        check("ill.seq", 32'(seq_err), 32'd1);
        check("ill.data", 32'(data_out), 32'hC3);
        step("clr", 3'b000, 8'h55, 1);
        check("clr.seq", 32'(seq_err), 32'd0);
        check("clr.cnt", 32'(xfer_cnt), 32'd0);
        legal_xfer("post_clr", 8'h5A, 0);

        // Counter wrap, then clr on a completion cycle.
        for (int i = 0; i < 255; i++) legal_xfer("wrap", 8'($urandom), 0);
        check("wrap.cnt", 32'(xfer_cnt), 32'd0);
        legal_xfer("clrdone", 8'h77, 1);
        check("clrdone.valid", 32'(valid), 32'd1);
        check("clrdone.cnt", 32'(xfer_cnt), 32'd0);

        // Source word changes while in ST2.
        step("mid", 3'b111, 8'h11, 0);
        step("mid", 3'b011, 8'h11, 0);
        step("mid", 3'b001, 8'h22, 0);
        step("mid", 3'b000, 8'h22, 0);
        check("mid.data", 32'(data_out), 32'h11);
`ifdef SYNC_CAPTURE_CHECK_EN
        check("mid.err", 32'(err), 32'd1);
`else
        check("mid.err", 32'(err), 32'd0);
`endif
        step("mid.clr", 3'b000, 8'h22, 1);

        // Asynchronous reset in ST2.
        step("rstmid", 3'b111, 8'h99, 0);
        step("rstmid", 3'b011, 8'h99, 0);
        check("rstmid.busy", 32'(busy), 32'd1);
        {ena_1, ena_2, ena_3} = 3'b000;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rstmid.in_reset");
        @(posedge clkB);
        #1;
        rst_n = 1'b1;
        legal_xfer("after_rst", 8'h6B, 0);
        check("after_rst.cnt", 32'(xfer_cnt), 32'd1);

        // Random mix of legal transfers, stray patterns, clears and data glitches.
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 9) < 6) begin
                for (int j = 0; j < 4; j++) begin
                    if ($urandom_range(0, 19) == 0) d = 8'($urandom);
                    step("rnd_seq", legal_seq[j], d, $urandom_range(0, 19) == 0);
                end
            end else begin
                step("rnd_e", 3'($urandom), d, $urandom_range(0, 19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
